stage_sequencer: RTL
====================

// Module: stage_sequencer
// PURPOSE
//  Five-stage instruction sequencer; drives Stage[2:0] into the stage-enable decoder.
//  Latches per-instruction decode controls at end of Decode and holds them through Write Back.
//  Stalls Memory on Mem_Wait, with a bounded timeout.
//  Handles Run/Halt and counts retired instructions.
// PARAMETERS
//  WAIT_LIMIT  8   max extra cycles Stage may hold at 4 while Mem_Wait=1
//  COUNT_W     16  width of Instr_Count
// PORTS
//  Clock                                   in   1        system clock; all state changes on posedge
//  Reset_n                                 in   1        synchronous, active-low reset
//  Run                                     in   1        1 = start or continue sequencing
//  NOP_In                                  in   1        decoder NOP indication; valid in stage 2
//  Halt_In                                 in   1        decoder HALT indication; valid in stage 2
//  MA_Select_Dec                           in   1        decoded memory-address mux select (1=PC, 0=RZ)
//  Mem_Op_Mem_Dec                          in   2        decoded memory op for stage 4
//  Mem_Op_WB_Dec                           in   2        decoded memory/RF op for stage 5
//  PC_Select_Dec                           in   2        decoded PC mux select for stage 5
//  INC_Select_Dec                          in   1        decoded PC increment select for stage 5
//  Jump_Dec                                in   1        instruction may redirect the PC (jump/branch)
//  Branch_Taken                            in   1        condition result from CCR; valid in stage 4
//  Mem_Wait                                in   1        memory not ready; meaningful in stage 4 only
//  Stage                                   out  3        0 idle, 1..5 F/D/E/M/WB, 7 halted
//  NOP_FLAG                                out  1        current instruction is a NOP
//  MA_Select_Memory_Stage                  out  1        latched MA_Select_Dec
//  Memory_Z_RM_WM_RF_Memory_Stage          out  2        latched Mem_Op_Mem_Dec
//  Memory_Z_RM_WM_RF_WriteBack_Stage       out  2        latched Mem_Op_WB_Dec
//  PC_Select_WriteBack_Stage               out  2        latched PC_Select_Dec
//  INC_Select_WriteBack_Stage              out  1        latched INC_Select_Dec
//  PC_Enable_Write_Back_Stage_Jump_Branch  out  1        PC reload enable in stage 5
//  Halted                                  out  1        Stage==7
//  Timeout_Error                           out  1        sticky; memory wait exceeded limit
//  Instr_Count                             out  COUNT_W  retired (non-NOP) instructions, wraps
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge, any state, overrides everything):
//   Stage=0; NOP_FLAG=0; MA_Select_Memory_Stage=1; both Mem_Op outs=0; PC_Select=2'b01;
//   INC_Select=0; PC_Enable_WB=0; Timeout_Error=0; Instr_Count=0; wait counter=0.
//  Transitions, evaluated per posedge:
//   0 -> 1 if Run, else hold.  1->2, 2->3, 3->4 unconditional.
//   4 -> 4 if Mem_Wait and wait counter < WAIT_LIMIT (counter++); 4 -> 7 and
//     Timeout_Error=1 if Mem_Wait and counter == WAIT_LIMIT; otherwise 4 -> 5.
//     Counter clears on entry to stage 4.
//   5 -> 7 if latched halt and !NOP_FLAG; else 5 -> 1 if Run; else 5 -> 0.
//     Halt has priority over Run=0.
//   7 -> 7 until reset.  Stage encodings 6 (illegal) -> 7 with Timeout_Error unchanged.
//  Latch at posedge with Stage==2: NOP_FLAG<=NOP_In; all *_Dec inputs and Halt_In captured.
//   If NOP_In=1: Mem_Op outs forced 0, MA_Select=1, PC_Select=2'b01, INC_Select=0, halt=0.
//   Values stay stable in stages 3..5 (including stall cycles).
//  On entry to stage 1: NOP_FLAG<=0 and PC_Enable_WB<=0; other latches keep their values.
//  PC_Enable_WB: at posedge leaving 4 -> 5, set to Jump_Dec_latched & Branch_Taken & !NOP_FLAG.
//   Zero in all other stages.
//  Instr_Count: increments on 5->{1,0,7} when !NOP_FLAG; wraps 2^COUNT_W-1 -> 0.
//  Mem_Wait ignored outside stage 4.  Run=0 mid-instruction: instruction completes, then idle.
//  Latency: 5 cycles per instruction plus stall cycles; Stage is a registered output.
// STRUCTURE
//  Shared package (cpu_pkg):
//   ST_IDLE=0, ST_FETCH=1, ST_DECODE=2, ST_EXEC=3, ST_MEM=4, ST_WB=5, ST_HALT=7;
//   MEM_NONE=0, MEM_READ=1, MEM_WRITE=2, MEM_LOAD_RF=3.
//  Sub-module stage_wait_timer: clear/inc/limit-hit counter, WAIT_LIMIT param, sync active-low reset.
// TESTING
//  Run=1, ADD (Mem_Op_WB=3, NOP_In=0) -> Stage 1,2,3,4,5,1; WB out=3 in stages 3-5;
//   Instr_Count 0->1.
//  NOP_In=1 in stage 2 with Mem_Op_WB_Dec=3 -> NOP_FLAG=1, WB out=0 in stages 3-5;
//   Instr_Count unchanged.
//  Mem_Wait=1 for 3 cycles in stage 4 (WAIT_LIMIT=8) -> Stage==4 for 4 cycles, then 5;
//   Timeout_Error=0.
//  Mem_Wait held high -> 9 cycles at 4, then Stage=7, Timeout_Error=1, Halted=1 until Reset_n=0.
//  Jump_Dec=1 and Branch_Taken=1 at end of stage 4 -> PC_Enable_WB=1 in stage 5 only.
//   Branch_Taken=0 -> stays 0.
//  Reset_n=0 during stage 3 -> next cycle Stage=0, all outputs at reset values.
//   Halt_In=1 at decode -> Stage 7 after 5; Instr_Count=2^16-1 -> wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer.
//   stage_e     : Stage encodings driven to the stage-enable decoder
//   MEM_*       : memory/register-file operation codes
//   dec_ctrl_t  : per-instruction decode controls held from Decode to Write Back
//   nop_ctrl()  : neutral control set used for NOPs and after reset
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd7
    } stage_e;

    localparam logic [1:0] MEM_NONE    = 2'd0;
    localparam logic [1:0] MEM_READ    = 2'd1;
    localparam logic [1:0] MEM_WRITE   = 2'd2;
    localparam logic [1:0] MEM_LOAD_RF = 2'd3;

    localparam logic [1:0] PC_SEL_DEFAULT = 2'b01;

    typedef struct packed {
        logic       ma_select;
        logic [1:0] mem_op_mem;
        logic [1:0] mem_op_wb;
        logic [1:0] pc_select;
        logic       inc_select;
        logic       jump;
        logic       halt;
    } dec_ctrl_t;

    // Controls that make an instruction side-effect free.
    function automatic dec_ctrl_t nop_ctrl();
        dec_ctrl_t c;
        c.ma_select  = 1'b1;
        c.mem_op_mem = MEM_NONE;
        c.mem_op_wb  = MEM_NONE;
        c.pc_select  = PC_SEL_DEFAULT;
        c.inc_select = 1'b0;
        c.jump       = 1'b0;
        c.halt       = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/stage_wait_timer.sv
// Memory-stall counter for the sequencer's Memory stage.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   clear     : zero the count (asserted on entry to Memory)
//   inc       : count one stall cycle; saturates at WAIT_LIMIT
//   limit_hit : count has reached WAIT_LIMIT
module stage_wait_timer #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic limit_hit
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && !limit_hit) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign limit_hit = (count_q == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer (Fetch/Decode/Execute/Memory/Write Back).
//   Clock, Reset_n      : clock, synchronous active-low reset
//   Run                 : start / continue sequencing
//   NOP_In, Halt_In     : decoder indications, sampled at the end of Decode
//   *_Dec               : decoded controls, latched at the end of Decode
//   Branch_Taken        : CCR condition, sampled leaving Memory
//   Mem_Wait            : memory not ready, honoured only in Memory
//   Stage               : 0 idle, 1..5 F/D/E/M/WB, 7 halted
//   *_Stage outputs     : latched decode controls, stable from Execute to Write Back
//   PC_Enable_...       : PC reload enable, high only in Write Back of a taken jump
//   Halted, Timeout_Error, Instr_Count : status
module stage_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 8,
    parameter int COUNT_W    = 16
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Run,
    input  logic               NOP_In,
    input  logic               Halt_In,
    input  logic               MA_Select_Dec,
    input  logic [1:0]         Mem_Op_Mem_Dec,
    input  logic [1:0]         Mem_Op_WB_Dec,
    input  logic [1:0]         PC_Select_Dec,
    input  logic               INC_Select_Dec,
    input  logic               Jump_Dec,
    input  logic               Branch_Taken,
    input  logic               Mem_Wait,
    output logic [2:0]         Stage,
    output logic               NOP_FLAG,
    output logic               MA_Select_Memory_Stage,
    output logic [1:0]         Memory_Z_RM_WM_RF_Memory_Stage,
    output logic [1:0]         Memory_Z_RM_WM_RF_WriteBack_Stage,
    output logic [1:0]         PC_Select_WriteBack_Stage,
    output logic               INC_Select_WriteBack_Stage,
    output logic               PC_Enable_Write_Back_Stage_Jump_Branch,
    output logic               Halted,
    output logic               Timeout_Error,
    output logic [COUNT_W-1:0] Instr_Count
);

    stage_e             stage_q, stage_d;
    dec_ctrl_t          ctrl_q, dec_in;
    logic               nop_flag_q;
    logic               pc_en_q;
    logic               timeout_q;
    logic [COUNT_W-1:0] count_q;
    logic               wait_clear, wait_inc, wait_hit, timeout_set;

    assign dec_in = '{ma_select:  MA_Select_Dec,
                      mem_op_mem: Mem_Op_Mem_Dec,
                      mem_op_wb:  Mem_Op_WB_Dec,
                      pc_select:  PC_Select_Dec,
                      inc_select: INC_Select_Dec,
                      jump:       Jump_Dec,
                      halt:       Halt_In};

    stage_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .clear     (wait_clear),
        .inc       (wait_inc),
        .limit_hit (wait_hit)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            stage_q <= ST_IDLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        stage_d     = stage_q;
        wait_clear  = 1'b0;
        wait_inc    = 1'b0;
        timeout_set = 1'b0;
        case (stage_q)
            ST_IDLE:   if (Run) stage_d = ST_FETCH;
            ST_FETCH:  stage_d = ST_DECODE;
            ST_DECODE: stage_d = ST_EXEC;
            ST_EXEC: begin
                stage_d    = ST_MEM;
                wait_clear = 1'b1;
            end
            ST_MEM: begin
                if (!Mem_Wait) begin
                    stage_d = ST_WB;
                end else if (wait_hit) begin
                    stage_d     = ST_HALT;
                    timeout_set = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                // A latched halt wins over both Run and Run=0.
                if (ctrl_q.halt && !nop_flag_q) stage_d = ST_HALT;
                else if (Run)                  stage_d = ST_FETCH;
                else                           stage_d = ST_IDLE;
            end
            ST_HALT:   stage_d = ST_HALT;
            default:   stage_d = ST_HALT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ctrl_q     <= nop_ctrl();
            nop_flag_q <= 1'b0;
            pc_en_q    <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            if (stage_q == ST_DECODE) begin
                nop_flag_q <= NOP_In;
                ctrl_q     <= NOP_In ? nop_ctrl() : dec_in;
            end else if (stage_d == ST_FETCH) begin
                nop_flag_q <= 1'b0;
            end

            // Only the Memory->Write Back edge can raise the PC reload.
            pc_en_q <= (stage_q == ST_MEM && stage_d == ST_WB) ?
                       (ctrl_q.jump & Branch_Taken & ~nop_flag_q) : 1'b0;

            if (timeout_set) timeout_q <= 1'b1;

            // Every exit from Write Back retires the instruction.
            if (stage_q == ST_WB && !nop_flag_q) count_q <= count_q + 1'b1;
        end
    end

    assign Stage                                  = stage_q;
    assign NOP_FLAG                               = nop_flag_q;
    assign MA_Select_Memory_Stage                 = ctrl_q.ma_select;
    assign Memory_Z_RM_WM_RF_Memory_Stage         = ctrl_q.mem_op_mem;
    assign Memory_Z_RM_WM_RF_WriteBack_Stage      = ctrl_q.mem_op_wb;
    assign PC_Select_WriteBack_Stage              = ctrl_q.pc_select;
    assign INC_Select_WriteBack_Stage             = ctrl_q.inc_select;
    assign PC_Enable_Write_Back_Stage_Jump_Branch = pc_en_q;
    assign Halted                                 = (stage_q == ST_HALT);
    assign Timeout_Error                          = timeout_q;
    assign Instr_Count                            = count_q;

endmodule
